// File: rtl/cpu_sequencer.sv
// Eight-state instruction sequencer for the 8-bit-data / 13-bit-address CPU.
// Optional bus wait states are enabled by defining CPU_SEQ_WAIT_EN.
module cpu_sequencer #(
  parameter bit HALT_STICKY = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  input  logic [2:0] opcode,
  input  logic       zero,
`ifdef CPU_SEQ_WAIT_EN
  input  logic       mem_ready,
`endif
  output logic       fetch,
  output logic       load_ir,
  output logic       inc_pc,
  output logic       load_pc,
  output logic       load_acc,
  output logic       rd,
  output logic       wr,
  output logic       datactl_ena,
  output logic       halt,
  output logic [2:0] state
);

  typedef enum logic [2:0] {S0, S1, S2, S3, S4, S5, S6, S7} state_e;

  localparam logic [2:0] OpHlt = 3'd0;
  localparam logic [2:0] OpSkz = 3'd1;
  localparam logic [2:0] OpAdd = 3'd2;
  localparam logic [2:0] OpAnd = 3'd3;
  localparam logic [2:0] OpXor = 3'd4;
  localparam logic [2:0] OpLda = 3'd5;
  localparam logic [2:0] OpSto = 3'd6;
  localparam logic [2:0] OpJmp = 3'd7;

  state_e     state_q, state_d;
  logic       run_q, run_d;
  logic       halted_q, halted_d;
  logic [2:0] op_q, op_d;
  logic       zero_q, zero_d;
  logic       ready;
  logic       advance;
  logic       is_alu;

`ifdef CPU_SEQ_WAIT_EN
  assign ready = mem_ready;
`else
  assign ready = 1'b1;
`endif

  // Outputs decode only registered state so IR/zero changes cannot glitch them.
  always_comb begin
    fetch       = 1'b0;
    load_ir     = 1'b0;
    inc_pc      = 1'b0;
    load_pc     = 1'b0;
    load_acc    = 1'b0;
    rd          = 1'b0;
    wr          = 1'b0;
    datactl_ena = 1'b0;
    halt        = 1'b0;
    is_alu      = (op_q == OpAdd) || (op_q == OpAnd) || (op_q == OpXor) || (op_q == OpLda);
    if (run_q && !halted_q) begin
      fetch = ~state_q[2];
      unique case (state_q)
        S0: begin
          rd      = 1'b1;
          load_ir = 1'b1;
          inc_pc  = 1'b1;
        end
        S1: begin
          rd      = 1'b1;
          load_ir = 1'b1;
        end
        S2: ;
        S3: begin
          inc_pc = 1'b1;
          halt   = (op_q == OpHlt);
        end
        S4: begin
          load_pc     = (op_q == OpJmp);
          rd          = is_alu;
          datactl_ena = (op_q == OpSto);
        end
        S5: begin
          load_pc     = (op_q == OpJmp);
          rd          = is_alu;
          load_acc    = is_alu;
          datactl_ena = (op_q == OpSto);
          wr          = (op_q == OpSto);
          inc_pc      = (op_q == OpSkz) && zero_q;
        end
        S6: begin
          rd          = is_alu;
          datactl_ena = (op_q == OpSto);
          inc_pc      = (op_q == OpSkz) && zero_q;
        end
        S7: ;
      endcase
    end
    if (halted_q) halt = 1'b1;
    // A bus state stalls until ready; one-shot strobes fire only on the completing cycle.
    advance  = ready || !(rd || wr);
    load_ir  = load_ir & advance;
    inc_pc   = inc_pc & advance;
    load_pc  = load_pc & advance;
    load_acc = load_acc & advance;
  end

  assign state = state_q;

  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    halted_d = halted_q;
    op_d     = op_q;
    zero_d   = zero_q;
    if (halted_q) begin
      // Frozen until reset.
    end else if (!run_q) begin
      state_d = S0;
      if (ena) run_d = 1'b1;
    end else if (advance) begin
      if (state_q == S2) op_d = opcode;
      if (state_q == S4) zero_d = zero;
      if (state_q == S3 && op_q == OpHlt && HALT_STICKY) begin
        halted_d = 1'b1;
      end else if (state_q == S7) begin
        state_d = S0;
        if (!ena) run_d = 1'b0;
      end else begin
        state_d = state_e'(state_q + 3'd1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S0;
      run_q    <= 1'b0;
      halted_q <= 1'b0;
      op_q     <= 3'd0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      halted_q <= halted_d;
      op_q     <= op_d;
      zero_q   <= zero_d;
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer (default build, HALT_STICKY=1).
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       ena;
  logic [2:0] opcode;
  logic       zero;
  logic       fetch, load_ir, inc_pc, load_pc, load_acc, rd, wr, datactl_ena, halt;
  logic [2:0] state;
  logic [11:0] obs;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, AND_OP = 3'd3;
  localparam logic [2:0] XOR_OP = 3'd4, LDA = 3'd5, STO = 3'd6, JMP = 3'd7;
  localparam logic [11:0] IDLE = 12'h000;
  localparam logic [11:0] HALTED = {9'b000000001, 3'd3};

  always #5 clk = ~clk;

  cpu_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .ena        (ena),
    .opcode     (opcode),
    .zero       (zero),
    .fetch      (fetch),
    .load_ir    (load_ir),
    .inc_pc     (inc_pc),
    .load_pc    (load_pc),
    .load_acc   (load_acc),
    .rd         (rd),
    .wr         (wr),
    .datactl_ena(datactl_ena),
    .halt       (halt),
    .state      (state)
  );

  assign obs = {fetch, load_ir, inc_pc, load_pc, load_acc, rd, wr, datactl_ena, halt, state};

  // Reference: strobes expected in phase p of an instruction with opcode op and latched zero z.
  function automatic logic [11:0] expect_vec(input int p, input logic [2:0] op, input logic z);
    logic f, lir, ipc, lpc, lacc, r, w, d, h, alu;
    alu  = (op == ADD) || (op == AND_OP) || (op == XOR_OP) || (op == LDA);
    f    = (p < 4);
    lir  = (p < 2);
    r    = (p < 2) || (alu && p >= 4 && p <= 6);
    ipc  = (p == 0) || (p == 3) || (op == SKZ && z && (p == 5 || p == 6));
    lpc  = (op == JMP) && (p == 4 || p == 5);
    lacc = alu && (p == 5);
    w    = (op == STO) && (p == 5);
    d    = (op == STO) && p >= 4 && p <= 6;
    h    = (op == HLT) && (p == 3);
    return {f, lir, ipc, lpc, lacc, r, w, d, h, 3'(p)};
  endfunction

  task automatic check(input string tag, input logic [11:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %b required %b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    vectors++;
    assert (got === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d required %0d", tag, got, exp);
    end
  endtask

  // Called at the negedge inside S0; returns at the negedge after S7.
  task automatic do_instr(input logic [2:0] op, input logic z, input bit drop_ena);
    int incs = 0;
    int wrs  = 0;
    opcode = op;
    zero   = z;
    for (int p = 0; p < 8; p++) begin
      check($sformatf("op%0d_z%0d_s%0d", op, z, p), expect_vec(p, op, z));
      incs += int'(inc_pc);
      wrs  += int'(wr);
      if (p == 2 && drop_ena) ena = 1'b0;
      if (p == 3) opcode = 3'($urandom);  // after the opcode latch
      if (p == 5) zero = 1'($urandom);    // after the zero latch
      @(negedge clk);
    end
    check_int($sformatf("inc_pc_count_op%0d_z%0d", op, z), incs, (op == SKZ && z) ? 4 : 2);
    check_int($sformatf("wr_count_op%0d", op), wrs, (op == STO) ? 1 : 0);
  endtask

  initial begin
    reset  = 1'b0;
    ena    = 1'b0;
    opcode = 3'd0;
    zero   = 1'b0;
    #2 check("reset_async", IDLE);
    @(negedge clk);
    check("reset_hold", IDLE);
    reset = 1'b1;
    @(negedge clk);
    check("idle_no_ena", IDLE);
    ena = 1'b1;
    @(negedge clk);

    do_instr(LDA, 1'b0, 1'b0);
    do_instr(STO, 1'b1, 1'b0);
    do_instr(SKZ, 1'b1, 1'b0);
    do_instr(SKZ, 1'b0, 1'b0);
    do_instr(JMP, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++)
      do_instr(3'($urandom_range(1, 7)), 1'($urandom), 1'b0);

    // Drop ena mid-instruction: completes through S7 then idles.
    do_instr(ADD, 1'b0, 1'b1);
    check("stopped_0", IDLE);
    @(negedge clk);
    check("stopped_1", IDLE);
    ena = 1'b1;
    @(negedge clk);

    // Asynchronous reset in S5 of STO.
    opcode = STO;
    zero   = 1'b0;
    for (int p = 0; p < 6; p++) begin
      check($sformatf("sto_pre_rst_s%0d", p), expect_vec(p, STO, 1'b0));
      if (p < 5) @(negedge clk);
    end
    reset = 1'b0;
    #1 check("rst_mid_sto", IDLE);
    ena = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_needs_ena", IDLE);
    ena = 1'b1;
    @(negedge clk);
    do_instr(XOR_OP, 1'b1, 1'b0);

    // Sticky halt.
    opcode = HLT;
    for (int p = 0; p < 4; p++) begin
      check($sformatf("hlt_s%0d", p), expect_vec(p, HLT, 1'b0));
      @(negedge clk);
    end
    for (int i = 0; i < 50; i++) begin
      opcode = 3'($urandom);
      ena    = 1'($urandom);
      check($sformatf("halted_%0d", i), HALTED);
      @(negedge clk);
    end
    reset = 1'b0;
    #1 check("rst_from_halt", IDLE);
    ena = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    do_instr(LDA, 1'b0, 1'b0);
    do_instr(SKZ, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
